// File: rtl/logic_op_arbiter.sv
// logic_op_arbiter
//   Round-robin arbiter and sequencer sharing one bitwise logic unit
//   (OR / NOR / XOR / XNOR) among 4 requesters.
//   sel_out[1] picks the group (0: OR family, 1: XOR family).
//   sel_out[0] inverts the result inside that group.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   req[3:0]          per-requester request, held until its ack completes
//   op_flat[7:0]      opcode of requester i at [2i+1:2i]
//   a_flat, b_flat    operands of requester i at [W*i+W-1:W*i]
//   ack               consumer accepts res (only looked at while res_valid)
//   grant[3:0]        one-hot owner of the unit, 0 when idle
//   sel_out[1:0]      latched opcode of the owner, 0 when idle
//   res, res_id       registered result and the index of its owner
//   res_valid         res is valid and held
//   busy              transaction in flight (EXEC or VALID)
//   done_count        completed transactions, wraps silently
module logic_op_arbiter #(
  parameter int W     = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       req,
  input  logic [7:0]       op_flat,
  input  logic [4*W-1:0]   a_flat,
  input  logic [4*W-1:0]   b_flat,
  input  logic             ack,
  output logic [3:0]       grant,
  output logic [1:0]       sel_out,
  output logic [W-1:0]     res,
  output logic [1:0]       res_id,
  output logic             res_valid,
  output logic             busy,
  output logic [CNT_W-1:0] done_count
);

  typedef enum logic [1:0] {IDLE, EXEC, VALID} state_t;

  state_t           state;
  logic [1:0]       last;
  logic [W-1:0]     lat_a, lat_b;

  // Per-requester views of the flat buses.
  logic [3:0][1:0]   op_v;
  logic [3:0][W-1:0] a_v, b_v;
  assign op_v = op_flat;
  assign a_v  = a_flat;
  assign b_v  = b_flat;

  // Round-robin pick: first set req bit scanning last+1 .. last+4 (mod 4).
  logic [1:0] win;
  logic       hit;
  always_comb begin
    win = '0;
    hit = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      if (!hit && req[last + 2'(k)]) begin
        win = last + 2'(k);
        hit = 1'b1;
      end
    end
  end

  // Shared logic unit: group select then optional inversion.
  logic [W-1:0] alu;
  assign alu = (sel_out[1] ? (lat_a ^ lat_b) : (lat_a | lat_b)) ^ {W{sel_out[0]}};

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last       <= 2'd3;
      grant      <= '0;
      sel_out    <= '0;
      res        <= '0;
      res_id     <= '0;
      res_valid  <= 1'b0;
      done_count <= '0;
      lat_a      <= '0;
      lat_b      <= '0;
    end else begin
      case (state)
        IDLE: if (hit) begin
          grant   <= 4'b0001 << win;
          res_id  <= win;
          sel_out <= op_v[win];
          lat_a   <= a_v[win];
          lat_b   <= b_v[win];
          state   <= EXEC;
        end
        EXEC: begin
          res       <= alu;
          res_valid <= 1'b1;
          state     <= VALID;
        end
        VALID: if (ack) begin
          // res and res_id intentionally keep their values after the handshake.
          res_valid  <= 1'b0;
          grant      <= '0;
          sel_out    <= '0;
          last       <= res_id;
          done_count <= done_count + CNT_W'(1);
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_logic_op_arbiter.sv
module tb_logic_op_arbiter;
  localparam int W = 4;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [3:0]       req;
  logic [7:0]       op_flat;
  logic [4*W-1:0]   a_flat, b_flat;
  logic             ack;
  logic [3:0]       grant;
  logic [1:0]       sel_out;
  logic [W-1:0]     res;
  logic [1:0]       res_id;
  logic             res_valid, busy;
  logic [CNT_W-1:0] done_count;

  logic_op_arbiter #(.W(W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .op_flat(op_flat),
    .a_flat(a_flat), .b_flat(b_flat), .ack(ack), .grant(grant),
    .sel_out(sel_out), .res(res), .res_id(res_id), .res_valid(res_valid),
    .busy(busy), .done_count(done_count)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int mdl_last = 3;
  int mdl_count = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] ref_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    case (o)
      2'd0: return x | y;
      2'd1: return ~(x | y);
      2'd2: return x ^ y;
      default: return ~(x ^ y);
    endcase
  endfunction

  function automatic int pick(input logic [3:0] r, input int lst);
    for (int k = 1; k <= 4; k++)
      if (r[(lst + k) % 4]) return (lst + k) % 4;
    return -1;
  endfunction

  task automatic scramble;
    req     = 4'($urandom);
    op_flat = 8'($urandom);
    a_flat  = 16'($urandom);
    b_flat  = 16'($urandom);
  endtask

  // One full transaction from IDLE; hold = cycles with ack low in VALID.
  task automatic do_txn(input logic [3:0] r, input logic [7:0] op, input logic [4*W-1:0] a,
                        input logic [4*W-1:0] b, input int hold, output int w);
    logic [1:0]   e_op;
    logic [W-1:0] e_res;
    req = r; op_flat = op; a_flat = a; b_flat = b; ack = 1'b0;
    w     = pick(r, mdl_last);
    e_op  = op[2*w +: 2];
    e_res = ref_op(e_op, a[W*w +: W], b[W*w +: W]);
    tick;
    chk("grant_e1",   grant,     32'(1 << w));
    chk("res_id_e1",  res_id,    32'(w));
    chk("sel_e1",     sel_out,   32'(e_op));
    chk("valid_e1",   res_valid, 0);
    chk("busy_e1",    busy,      1);
    scramble;
    ack = 1'($urandom);
    tick;
    chk("valid_e2",   res_valid, 1);
    chk("res_e2",     res,       32'(e_res));
    chk("res_id_e2",  res_id,    32'(w));
    for (int i = 0; i < hold; i++) begin
      ack = 1'b0;
      scramble;
      tick;
      chk("hold_res",   res,       32'(e_res));
      chk("hold_id",    res_id,    32'(w));
      chk("hold_sel",   sel_out,   32'(e_op));
      chk("hold_grant", grant,     32'(1 << w));
      chk("hold_valid", res_valid, 1);
    end
    ack = 1'b1;
    tick;
    mdl_last  = w;
    mdl_count = (mdl_count + 1) % (1 << CNT_W);
    chk("ack_valid", res_valid,  0);
    chk("ack_grant", grant,      0);
    chk("ack_sel",   sel_out,    0);
    chk("ack_busy",  busy,       0);
    chk("ack_count", done_count, 32'(mdl_count));
    chk("ack_res",   res,        32'(e_res));
    chk("ack_id",    res_id,     32'(w));
    req = '0; ack = 1'b0;
  endtask

  int w;
  int fair1[5] = '{0, 1, 2, 3, 0};
  int fair2[3] = '{1, 3, 1};

  initial begin
    // Reset with random inputs.
    rst_n = 1'b0; scramble; ack = 1'b1;
    #2;
    chk("rst_grant", grant, 0);
    chk("rst_sel",   sel_out, 0);
    chk("rst_res",   res, 0);
    chk("rst_id",    res_id, 0);
    chk("rst_valid", res_valid, 0);
    chk("rst_busy",  busy, 0);
    chk("rst_count", done_count, 0);
    req = '0; ack = 1'b0;
    #1 rst_n = 1'b1;
    repeat (5) begin
      tick;
      chk("idle_grant", grant, 0);
      chk("idle_busy",  busy, 0);
    end

    // Single XOR request from requester 0: 1010 ^ 0110 = 1100.
    do_txn(4'b0001, 8'h02, 16'h000A, 16'h0006, 0, w);
    chk("xor_res", res, 32'hC);
    // NOR then XNOR on requester 2.
    do_txn(4'b0100, 8'h10, 16'h0300, 16'h0500, 0, w);
    chk("nor_res", res, 32'h8);
    do_txn(4'b0100, 8'h30, 16'h0300, 16'h0500, 0, w);
    chk("xnor_res", res, 32'h9);

    // Fairness: reset pointer back to 3 first.
    rst_n = 1'b0; #1 rst_n = 1'b1;
    mdl_last = 3; mdl_count = 0;
    foreach (fair1[i]) begin
      do_txn(4'b1111, 8'($urandom), 16'($urandom), 16'($urandom), 0, w);
      chk("fair_all", 32'(w), 32'(fair1[i]));
      chk("fair_all_id", res_id, 32'(fair1[i]));
    end
    foreach (fair2[i]) begin
      do_txn(4'b1010, 8'($urandom), 16'($urandom), 16'($urandom), 0, w);
      chk("fair_1010_id", res_id, 32'(fair2[i]));
    end

    // Held result with inputs churning.
    do_txn(4'($urandom_range(1, 15)), 8'($urandom), 16'($urandom), 16'($urandom), 10, w);

    // Reset during VALID.
    req = 4'b0010; ack = 1'b0;
    tick; tick;
    chk("pre_rst_valid", res_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", res_valid, 0);
    chk("mid_rst_count", done_count, 0);
    chk("mid_rst_busy",  busy, 0);
    chk("mid_rst_grant", grant, 0);
    req = '0;
    #1 rst_n = 1'b1;
    mdl_last = 3; mdl_count = 0;

    // 256 random transactions: counter wraps back to 0.
    for (int t = 0; t < 256; t++)
      do_txn(4'($urandom_range(1, 15)), 8'($urandom), 16'($urandom), 16'($urandom),
             $urandom_range(0, 2), w);
    chk("wrap_count", done_count, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
